// File: rtl/ehl_rst_seq.sv
// ehl_rst_seq: staged reset sequencer with sticky cause register and watchdog-preserving reset.
// Optional reset-episode counter at addr 3 enabled by EHL_RST_SEQ_COUNT_EN.
module ehl_rst_seq #(
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4,
    parameter int CW          = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wdt_rst_req,
    input  logic          ext_rst_req,
    input  logic          wr,
    input  logic          rd,
    input  logic [1:0]    addr,
    input  logic [CW-1:0] wdata,
    output logic [CW-1:0] rdata,
    output logic          bus_reset_n,
    output logic          cpu_reset_n,
    output logic          wdt_reset_n,
    output logic          busy
);
    localparam logic [1:0] ASSERT  = 2'd0;
    localparam logic [1:0] REL_BUS = 2'd1;
    localparam logic [1:0] IDLE    = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, hold_q, load_val, count_rd, rd_val;
    logic [3:0]    cause_q, cause_d;
    logic          full_q, full_d, sw_req, req;

    assign sw_req   = wr && addr == 2'd2 && wdata[0];
    assign req      = wdt_rst_req | ext_rst_req | sw_req;
    assign load_val = (hold_q == '0) ? '0 : hold_q - 1'b1;
    assign rd_val   = addr == 2'd0 ? CW'(cause_q) : addr == 2'd1 ? hold_q : addr == 2'd3 ? count_rd : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 1'b1;
        if (req) begin
            state_d = ASSERT;
            cnt_d   = load_val;
        end else if (state_q == ASSERT && cnt_q == '0) begin
            state_d = REL_BUS;
            cnt_d   = CW'(STAGE_GAP - 1);
        end else if (state_q == REL_BUS && cnt_q == '0) begin
            state_d = IDLE;
        end else if (state_q != ASSERT && state_q != REL_BUS) begin
            state_d = IDLE;
            cnt_d   = cnt_q;
        end
    end

    // full marks a POR/external episode; only those also reset the watchdog
    assign full_d  = ext_rst_req | (full_q & (state_d != IDLE));
    assign cause_d = (cause_q & ~((wr && addr == 2'd0) ? wdata[3:0] : 4'h0))
                   | {ext_rst_req, sw_req, wdt_rst_req, 1'b0};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ASSERT;
            cnt_q       <= CW'(HOLD_CYCLES - 1);
            cause_q     <= 4'h1;
            full_q      <= 1'b1;
            hold_q      <= CW'(HOLD_CYCLES);
            rdata       <= '0;
            bus_reset_n <= 1'b0;
            cpu_reset_n <= 1'b0;
            wdt_reset_n <= 1'b0;
            busy        <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cause_q     <= cause_d;
            full_q      <= full_d;
            if (wr && addr == 2'd1) hold_q <= wdata;
            if (rd) rdata <= rd_val;
            bus_reset_n <= state_d != ASSERT;
            cpu_reset_n <= state_d == IDLE;
            wdt_reset_n <= !(state_d == ASSERT && full_d);
            busy        <= state_d != IDLE;
        end
    end

`ifdef EHL_RST_SEQ_COUNT_EN
    logic [CW-1:0] count_q;
    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else if (wr && addr == 2'd3) count_q <= '0;
        else if (req && state_q != ASSERT && count_q != '1) count_q <= count_q + 1'b1;
    end
    assign count_rd = count_q;
`else
    assign count_rd = '0;
`endif
endmodule

// File: tb/tb_ehl_rst_seq.sv
// tb_ehl_rst_seq: directed checks of reset staging, cause register, hold length and episode count.
module tb_ehl_rst_seq;
    logic       clk = 1'b0, reset = 1'b1, wdt_rst_req = 1'b0, ext_rst_req = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] wdata = 8'h00, rdata;
    logic       bus_reset_n, cpu_reset_n, wdt_reset_n, busy;
    int         errors = 0, checks = 0;

    ehl_rst_seq dut (
        .clk(clk), .reset(reset), .wdt_rst_req(wdt_rst_req), .ext_rst_req(ext_rst_req),
        .wr(wr), .rd(rd), .addr(addr), .wdata(wdata), .rdata(rdata),
        .bus_reset_n(bus_reset_n), .cpu_reset_n(cpu_reset_n), .wdt_reset_n(wdt_reset_n), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic b, input logic c, input logic w, input logic y);
        chk(tag, {4'h0, bus_reset_n, cpu_reset_n, wdt_reset_n, busy}, {4'h0, b, c, w, y});
    endtask

    task automatic wreg(input logic [1:0] a, input logic [7:0] d);
        wr = 1'b1; addr = a; wdata = d;
        tick(1);
        wr = 1'b0;
    endtask

    task automatic rreg(input string tag, input logic [1:0] a, input logic [7:0] exp);
        rd = 1'b1; addr = a;
        tick(1);
        rd = 1'b0;
        chk(tag, rdata, exp);
    endtask

    task automatic wdt_pulse();
        wdt_rst_req = 1'b1;
        tick(1);
        wdt_rst_req = 1'b0;
    endtask

    initial begin
        logic [7:0] cnt_all, cnt3;
`ifdef EHL_RST_SEQ_COUNT_EN
        cnt_all = 8'd7; cnt3 = 8'd3;
`else
        cnt_all = 8'd0; cnt3 = 8'd0;
`endif
        tick(3);
        outs("por_outs", 0, 0, 0, 1);
        chk("por_rdata", rdata, 8'h00);
        reset = 1'b0;
        tick(15);
        outs("por_hold15", 0, 0, 0, 1);
        tick(1);
        outs("por_relbus", 1, 0, 1, 1);
        tick(3);
        outs("por_gap3", 1, 0, 1, 1);
        tick(1);
        outs("por_idle", 1, 1, 1, 0);
        rreg("cause_por", 2'd0, 8'h01);
        rreg("hold_rst", 2'd1, 8'h10);
        rreg("count_rst", 2'd3, 8'h00);
        wreg(2'd1, 8'h04);
        wreg(2'd0, 8'h01);
        rreg("cause_clr", 2'd0, 8'h00);
        wdt_pulse();
        outs("wdt_assert", 0, 0, 1, 1);
        tick(3);
        outs("wdt_hold4", 0, 0, 1, 1);
        tick(1);
        outs("wdt_relbus", 1, 0, 1, 1);
        tick(4);
        outs("wdt_idle", 1, 1, 1, 0);
        rreg("cause_wdt", 2'd0, 8'h02);
        wreg(2'd0, 8'h02);
        ext_rst_req = 1'b1;
        tick(1);
        ext_rst_req = 1'b0;
        outs("ext_assert", 0, 0, 0, 1);
        tick(3);
        outs("ext_hold4", 0, 0, 0, 1);
        tick(1);
        outs("ext_relbus", 1, 0, 1, 1);
        tick(4);
        outs("ext_idle", 1, 1, 1, 0);
        rreg("cause_ext", 2'd0, 8'h08);
        wreg(2'd0, 8'h08);
        wdt_pulse();
        tick(4);
        outs("sw_pre_relbus", 1, 0, 1, 1);
        wreg(2'd2, 8'h01);
        outs("sw_reassert", 0, 0, 1, 1);
        tick(3);
        outs("sw_hold4", 0, 0, 1, 1);
        tick(1);
        outs("sw_relbus", 1, 0, 1, 1);
        tick(4);
        outs("sw_idle", 1, 1, 1, 0);
        rreg("cause_sw", 2'd0, 8'h06);
        rreg("ctrl_read", 2'd2, 8'h00);
        wreg(2'd0, 8'h0F);
        wdt_rst_req = 1'b1; ext_rst_req = 1'b1;
        tick(1);
        wdt_rst_req = 1'b0; ext_rst_req = 1'b0;
        outs("both_assert", 0, 0, 0, 1);
        rreg("cause_both", 2'd0, 8'h0A);
        wreg(2'd0, 8'h0F);
        rreg("cause_w1c", 2'd0, 8'h00);
        tick(5);
        outs("both_idle", 1, 1, 1, 0);
        wdt_rst_req = 1'b1; wr = 1'b1; addr = 2'd0; wdata = 8'h02;
        tick(1);
        wdt_rst_req = 1'b0; wr = 1'b0;
        rreg("cause_set_wins", 2'd0, 8'h02);
        tick(7);
        outs("setwin_idle", 1, 1, 1, 0);
        wdt_rst_req = 1'b1;
        tick(10);
        wdt_rst_req = 1'b0;
        outs("held_assert", 0, 0, 1, 1);
        tick(3);
        outs("held_tail", 0, 0, 1, 1);
        tick(1);
        outs("held_relbus", 1, 0, 1, 1);
        tick(4);
        outs("held_idle", 1, 1, 1, 0);
        rreg("count_all", 2'd3, cnt_all);
        wreg(2'd3, 8'h00);
        rreg("count_clr", 2'd3, 8'h00);
        wdt_pulse();
        tick(8);
        wdt_pulse();
        tick(8);
        wdt_pulse();
        tick(2);
        wdt_pulse();
        tick(8);
        outs("cnt_idle", 1, 1, 1, 0);
        rreg("count3", 2'd3, cnt3);
        wreg(2'd1, 8'h00);
        rreg("hold_zero", 2'd1, 8'h00);
        wdt_pulse();
        outs("hold0_assert", 0, 0, 1, 1);
        tick(1);
        outs("hold0_relbus", 1, 0, 1, 1);
        tick(4);
        outs("hold0_idle", 1, 1, 1, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
